alu_result_fifo: RTL and testbench

//  Result buffer that sits directly downstream of the 2-stage registered ALU. The ALU has no

---
 rtl/alu_result_fifo.sv | 109 ++++++++++
 tb/tb_alu_result_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_fifo
//  Description : Result buffer behind the 2-stage ALU. It accepts ALU results
//                without backpressure, presents them first-word fall-through
//                on a valid/ready handshake, and issues credits (issue_ok) so
//                that the issuer never overruns the buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_result_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int PIPE_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     issue_ok
);

    localparam int PW      = $clog2(DEPTH);
    localparam int CW      = PW + 1;
    // In-flight ops can never legitimately exceed the pipeline plus the buffer.
    localparam int INF_MAX = PIPE_LAT + DEPTH;
    localparam int IW      = $clog2(INF_MAX + 1);
    // One extra bit so count + inflight cannot wrap before the compare.
    localparam int SW      = ((IW > CW) ? IW : CW) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [IW-1:0]    inflight_q, inflight_d;
    logic             overflow_q, overflow_d;

    logic             w_pop;
    logic             w_push;
    logic             w_arr;
    logic [SW-1:0]    w_credit_sum;

    // Status decode from registered state only; no input reaches these outputs.
    always_comb begin
        empty        = (count_q == '0);
        full         = (count_q == CW'(DEPTH));
        out_valid    = !empty;
        out_data     = empty ? '0 : mem_q[rd_ptr_q];
        count        = count_q;
        overflow     = overflow_q;
        w_credit_sum = SW'(count_q) + SW'(inflight_q);
        issue_ok     = (w_credit_sum < SW'(DEPTH));
    end

    // Next-state: pointers, occupancy, sticky overflow and the in-flight credit counter.
    always_comb begin
        w_pop      = out_valid & out_ready;
        w_push     = in_valid & (!full | w_pop);
        w_arr      = in_valid & (inflight_q != '0);
        wr_ptr_d   = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_push && w_pop) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = overflow_q | (in_valid & !w_push);
        inflight_d = inflight_q;
        if (issue && !w_arr && (inflight_q != IW'(INF_MAX))) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!issue && w_arr) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    // Control state registers with immediate asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_result_fifo
//  Description : Directed self-checking bench for alu_result_fifo
//                (WIDTH=8, DEPTH=4, PIPE_LAT=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       issue = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       issue_ok;

    int checks = 0;
    int errors = 0;

    alu_result_fifo #(.WIDTH(8), .DEPTH(4), .PIPE_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .issue_ok  (issue_ok)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and checks both happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_rst();
        #1 rst = 1'b1;
        #1;
        chk("rst_empty_now", {31'd0, empty}, 32'd1);
        chk("rst_count_now", {29'd0, count}, 32'd0);
        chk("rst_ovf_now", {31'd0, overflow}, 32'd0);
        chk("rst_ok_now", {31'd0, issue_ok}, 32'd1);
        rst = 1'b0;
    endtask

    initial begin
        // ---- 1: reset, then async reset asserted mid-cycle ----
        #12 rst = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 8'h99;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_count", {29'd0, count}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t1_empty", {31'd0, empty}, 32'd1);
        chk("t1_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_out_data", {24'd0, out_data}, 32'd0);
        chk("t1_full", {31'd0, full}, 32'd0);
        chk("t1_issue_ok", {31'd0, issue_ok}, 32'd1);
        chk("t1_count", {29'd0, count}, 32'd0);
        rst = 1'b0;
        tick();

        // ---- 2: three pushes then drain in order ----
        in_valid = 1'b1; in_data = 8'h05; tick();
        in_data = 8'h0A; tick();
        in_data = 8'hFF; tick();
        in_valid = 1'b0;
        chk("t2_count3", {29'd0, count}, 32'd3);
        chk("t2_head05", {24'd0, out_data}, 32'h05);
        out_ready = 1'b1;
        tick();
        chk("t2_head0A", {24'd0, out_data}, 32'h0A);
        tick();
        chk("t2_headFF", {24'd0, out_data}, 32'hFF);
        tick();
        chk("t2_empty", {31'd0, empty}, 32'd1);
        chk("t2_data0", {24'd0, out_data}, 32'd0);
        tick();
        chk("t2_no_underflow", {29'd0, count}, 32'd0);
        out_ready = 1'b0;

        // ---- 3: fill, then overflow on a non-popping write ----
        in_valid = 1'b1;
        in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_data = 8'h33; tick();
        in_data = 8'h44; tick();
        chk("t3_full", {31'd0, full}, 32'd1);
        chk("t3_ok_full", {31'd0, issue_ok}, 32'd0);
        chk("t3_ovf_before", {31'd0, overflow}, 32'd0);
        in_data = 8'h77; tick();
        in_valid = 1'b0;
        chk("t3_overflow", {31'd0, overflow}, 32'd1);
        chk("t3_count4", {29'd0, count}, 32'd4);
        out_ready = 1'b1;
        chk("t3_pop11", {24'd0, out_data}, 32'h11); tick();
        chk("t3_pop22", {24'd0, out_data}, 32'h22); tick();
        chk("t3_pop33", {24'd0, out_data}, 32'h33); tick();
        chk("t3_pop44", {24'd0, out_data}, 32'h44); tick();
        chk("t3_empty", {31'd0, empty}, 32'd1);
        chk("t3_sticky", {31'd0, overflow}, 32'd1);
        out_ready = 1'b0;
        pulse_rst();
        tick();

        // ---- 4: full with simultaneous write and pop ----
        in_valid = 1'b1;
        in_data = 8'hA1; tick();
        in_data = 8'hA2; tick();
        in_data = 8'hA3; tick();
        in_data = 8'hA4; tick();
        chk("t4_full", {31'd0, full}, 32'd1);
        in_data = 8'h33; out_ready = 1'b1;
        chk("t4_headA1", {24'd0, out_data}, 32'hA1);
        tick();
        in_valid = 1'b0;
        chk("t4_count4", {29'd0, count}, 32'd4);
        chk("t4_no_ovf", {31'd0, overflow}, 32'd0);
        chk("t4_headA2", {24'd0, out_data}, 32'hA2); tick();
        chk("t4_headA3", {24'd0, out_data}, 32'hA3); tick();
        chk("t4_headA4", {24'd0, out_data}, 32'hA4); tick();
        chk("t4_head33", {24'd0, out_data}, 32'h33); tick();
        chk("t4_empty", {31'd0, empty}, 32'd1);
        out_ready = 1'b0;

        // ---- 5: credit accounting with in-flight ops ----
        in_valid = 1'b1; in_data = 8'h5C; tick();
        in_valid = 1'b0;
        issue = 1'b1;
        tick();
        chk("t5_ok_i1", {31'd0, issue_ok}, 32'd1);
        tick();
        chk("t5_ok_i2", {31'd0, issue_ok}, 32'd1);
        tick();
        issue = 1'b0;
        chk("t5_ok_i3", {31'd0, issue_ok}, 32'd0);
        in_valid = 1'b1;
        in_data = 8'hD1; tick();
        chk("t5_ok_a1", {31'd0, issue_ok}, 32'd0);
        in_data = 8'hD2; tick();
        chk("t5_ok_a2", {31'd0, issue_ok}, 32'd0);
        in_data = 8'hD3; tick();
        in_valid = 1'b0;
        chk("t5_ok_a3", {31'd0, issue_ok}, 32'd0);
        chk("t5_count4", {29'd0, count}, 32'd4);
        out_ready = 1'b1; tick();
        out_ready = 1'b0;
        chk("t5_ok_pop", {31'd0, issue_ok}, 32'd1);
        chk("t5_headD1", {24'd0, out_data}, 32'hD1);
        chk("t5_no_ovf", {31'd0, overflow}, 32'd0);

        // ---- 6: reset clears count, inflight and overflow ----
        in_valid = 1'b1;
        in_data = 8'hE1; tick();
        in_data = 8'hE2; tick();
        in_valid = 1'b0;
        chk("t6_ovf", {31'd0, overflow}, 32'd1);
        out_ready = 1'b1; tick(); tick();
        out_ready = 1'b0;
        issue = 1'b1; tick();
        issue = 1'b0;
        chk("t6_count2", {29'd0, count}, 32'd2);
        chk("t6_ok_pre", {31'd0, issue_ok}, 32'd1);
        pulse_rst();
        tick();
        // A leftover in-flight credit would make the third issue exhaust credits.
        issue = 1'b1; tick(); tick(); tick();
        issue = 1'b0;
        chk("t6_inflight_cleared", {31'd0, issue_ok}, 32'd1);
        in_valid = 1'b1; in_data = 8'h42;
        #1;
        chk("t6_no_bypass", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("t6_data42", {24'd0, out_data}, 32'h42);
        chk("t6_count1", {29'd0, count}, 32'd1);
        chk("t6_ok_after", {31'd0, issue_ok}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
